// File: rtl/wb_port_arbiter_if.sv
// Bundle between the writeback mux / MDU and the register-file write port.
// The arbiter uses the slave modport; its driver side uses master.
interface wb_port_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 2
);
    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          mdu_valid;
    logic [AW-1:0] mdu_waddr;
    logic [DW-1:0] mdu_wdata;
    logic          mdu_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pipe_stall;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata, mdu_valid, mdu_waddr, mdu_wdata,
        output mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, fifo_count
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata, mdu_valid, mdu_waddr, mdu_wdata,
        input  mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: writeback result first, MDU results queued and
// drained in idle slots, with starvation stall. WB_BYPASS_EN: idle-port MDU bypass.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4,
    parameter int AW         = 5,
    parameter int DW         = 32
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [3:0]    starve, starve_nxt;
    logic          pipe_req, fifo_empty, xfer, push, pop, bypass;

    assign pipe_req       = bus.pipe_we && (bus.pipe_waddr != '0);
    assign fifo_empty     = (count == '0);
    assign bus.mdu_ready  = (count < CW'(DEPTH));
    assign xfer           = bus.mdu_valid && bus.mdu_ready;
    assign pop            = !pipe_req && !fifo_empty;
    assign bus.fifo_count = count;

`ifdef WB_BYPASS_EN
    assign bypass = xfer && fifo_empty && !pipe_req && (bus.mdu_waddr != '0);
`else
    assign bypass = 1'b0;
`endif

    // Writes to $0 are swallowed at the handshake and never occupy a slot.
    assign push = xfer && (bus.mdu_waddr != '0) && !bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.mdu_waddr;
            q_data[wr_ptr] <= bus.mdu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else if (pipe_req) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= bus.pipe_waddr;
            bus.rf_wdata <= bus.pipe_wdata;
        end else if (pop) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= q_addr[rd_ptr];
            bus.rf_wdata <= q_data[rd_ptr];
        end else if (bypass) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= bus.mdu_waddr;
            bus.rf_wdata <= bus.mdu_wdata;
        end else begin
            bus.rf_we    <= 1'b0;
        end
    end

    // Counts cycles the queue head is blocked by the pipeline; saturates.
    always_comb begin
        starve_nxt = starve;
        if (pop || fifo_empty)
            starve_nxt = '0;
        else if (pipe_req && starve != SMAX)
            starve_nxt = starve + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve <= '0;
        end else begin
            starve <= starve_nxt;
        end
    end

    // Stall is asserted on the edge the counter reaches its limit and dropped on the pop edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= NORMAL;
            bus.pipe_stall <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (starve_nxt == SMAX) begin
                        state          <= FORCE;
                        bus.pipe_stall <= 1'b1;
                    end
                end
                FORCE: begin
                    if (pop) begin
                        state          <= NORMAL;
                        bus.pipe_stall <= 1'b0;
                    end
                end
                default: begin
                    state          <= NORMAL;
                    bus.pipe_stall <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_MAX=4); honours WB_BYPASS_EN.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.AW(5), .DW(32), .CW(2)) bus ();

    wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4), .AW(5), .DW(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.pipe_we = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
        bus.mdu_valid = 1'b0; bus.mdu_waddr = '0; bus.mdu_wdata = '0;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); end
        n_cmp++; if (bus.rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_rf_waddr got %h exp 0", bus.rf_waddr); end
        n_cmp++; if (bus.rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_rf_wdata got %h exp 0", bus.rf_wdata); end
        n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", bus.pipe_stall); end
        n_cmp++; if (bus.fifo_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.fifo_count); end
        n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", bus.mdu_ready); end
    endtask

    task automatic test_priority();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'hDEADBEEF;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd9; bus.mdu_wdata = 32'h11;
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8 || bus.rf_wdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL prio_pipe1 got %b/%0d/%h exp 1/8/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_cmp++; if (bus.fifo_count !== 2'd1) begin n_err++; $display("FAIL prio_count1 got %0d exp 1", bus.fifo_count); end
        bus.mdu_valid = 1'b0;
        cyc();
        n_cmp++; if (bus.rf_waddr !== 5'd8 || bus.fifo_count !== 2'd1) begin
            n_err++; $display("FAIL prio_pipe2 got %0d/%0d exp 8/1", bus.rf_waddr, bus.fifo_count); end
        bus.pipe_we = 1'b0;
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h11) begin
            n_err++; $display("FAIL prio_drain got %b/%0d/%h exp 1/9/11", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_cmp++; if (bus.fifo_count !== 2'd0) begin n_err++; $display("FAIL prio_count0 got %0d exp 0", bus.fifo_count); end
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd9) begin
            n_err++; $display("FAIL prio_idle got %b/%0d exp 0/9", bus.rf_we, bus.rf_waddr); end
    endtask

    task automatic test_full();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'hAAAA;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd10; bus.mdu_wdata = 32'hA1;
        cyc();
        n_cmp++; if (bus.fifo_count !== 2'd1) begin n_err++; $display("FAIL full_count1 got %0d exp 1", bus.fifo_count); end
        bus.mdu_waddr = 5'd11; bus.mdu_wdata = 32'hA2;
        n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready1 got %b exp 1", bus.mdu_ready); end
        cyc();
        n_cmp++; if (bus.fifo_count !== 2'd2 || bus.mdu_ready !== 1'b0) begin
            n_err++; $display("FAIL full_at2 got %0d/%b exp 2/0", bus.fifo_count, bus.mdu_ready); end
        bus.mdu_waddr = 5'd12; bus.mdu_wdata = 32'hA3;
        cyc();
        n_cmp++; if (bus.fifo_count !== 2'd2 || bus.mdu_ready !== 1'b0 || bus.pipe_stall !== 1'b0) begin
            n_err++; $display("FAIL full_held got %0d/%b/%b exp 2/0/0", bus.fifo_count, bus.mdu_ready, bus.pipe_stall); end
        bus.pipe_we = 1'b0;
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'hA1 || bus.fifo_count !== 2'd1) begin
            n_err++; $display("FAIL full_pop1 got %b/%0d/%h/%0d exp 1/10/a1/1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fifo_count); end
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 32'hA2 || bus.fifo_count !== 2'd1) begin
            n_err++; $display("FAIL full_pop2 got %b/%0d/%h/%0d exp 1/11/a2/1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fifo_count); end
        bus.mdu_valid = 1'b0;
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'hA3 || bus.fifo_count !== 2'd0) begin
            n_err++; $display("FAIL full_pop3 got %b/%0d/%h/%0d exp 1/12/a3/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fifo_count); end
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL full_nodup got %b exp 0", bus.rf_we); end
    endtask

    task automatic test_starve();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'hBBBB;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd13; bus.mdu_wdata = 32'h77;
        cyc();
        bus.mdu_valid = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_err++; $display("FAIL starve_early got %b exp 0", bus.pipe_stall); end
        cyc();
        n_cmp++; if (bus.pipe_stall !== 1'b1) begin n_err++; $display("FAIL starve_force got %b exp 1", bus.pipe_stall); end
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8) begin
            n_err++; $display("FAIL starve_pipe_grant got %b/%0d exp 1/8", bus.rf_we, bus.rf_waddr); end
        cyc();
        n_cmp++; if (bus.pipe_stall !== 1'b1 || bus.fifo_count !== 2'd1) begin
            n_err++; $display("FAIL starve_hold got %b/%0d exp 1/1", bus.pipe_stall, bus.fifo_count); end
        bus.pipe_we = 1'b0;
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd13 || bus.rf_wdata !== 32'h77) begin
            n_err++; $display("FAIL starve_pop got %b/%0d/%h exp 1/13/77", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_cmp++; if (bus.pipe_stall !== 1'b0 || bus.fifo_count !== 2'd0) begin
            n_err++; $display("FAIL starve_release got %b/%0d exp 0/0", bus.pipe_stall, bus.fifo_count); end
        cyc();
    endtask

    task automatic test_zero();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'hCCCC;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd14; bus.mdu_wdata = 32'h99;
        cyc();
        bus.mdu_valid = 1'b0; bus.pipe_waddr = 5'd0; bus.pipe_wdata = 32'h1234;
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd14 || bus.rf_wdata !== 32'h99 || bus.fifo_count !== 2'd0) begin
            n_err++; $display("FAIL zero_pipe got %b/%0d/%h/%0d exp 1/14/99/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fifo_count); end
        bus.pipe_we = 1'b0;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd0; bus.mdu_wdata = 32'h55;
        cyc();
        n_cmp++; if (bus.fifo_count !== 2'd0 || bus.rf_we !== 1'b0) begin
            n_err++; $display("FAIL zero_mdu got %0d/%b exp 0/0", bus.fifo_count, bus.rf_we); end
        bus.mdu_valid = 1'b0;
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd14) begin
            n_err++; $display("FAIL zero_mdu_late got %b/%0d exp 0/14", bus.rf_we, bus.rf_waddr); end
    endtask

    task automatic test_latency();
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd3; bus.mdu_wdata = 32'h5;
        cyc();
        bus.mdu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h5 || bus.fifo_count !== 2'd0) begin
            n_err++; $display("FAIL lat_n1 got %b/%0d/%h/%0d exp 1/3/5/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fifo_count); end
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL lat_n2 got %b exp 0", bus.rf_we); end
`else
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.fifo_count !== 2'd1) begin
            n_err++; $display("FAIL lat_n1 got %b/%0d exp 0/1", bus.rf_we, bus.fifo_count); end
        cyc();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h5 || bus.fifo_count !== 2'd0) begin
            n_err++; $display("FAIL lat_n2 got %b/%0d/%h/%0d exp 1/3/5/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fifo_count); end
`endif
        cyc();
    endtask

    task automatic test_mid_reset();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'hDDDD;
        bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd15; bus.mdu_wdata = 32'hC1;
        cyc();
        bus.mdu_waddr = 5'd16; bus.mdu_wdata = 32'hC2;
        cyc();
        n_cmp++; if (bus.fifo_count !== 2'd2) begin n_err++; $display("FAIL mrst_pre got %0d exp 2", bus.fifo_count); end
        bus.mdu_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.pipe_stall !== 1'b0 || bus.fifo_count !== 2'd0 || bus.mdu_ready !== 1'b1) begin
            n_err++; $display("FAIL mrst_async got %b/%b/%0d/%b exp 0/0/0/1", bus.rf_we, bus.pipe_stall, bus.fifo_count, bus.mdu_ready); end
        idle_inputs();
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++; if (bus.rf_we !== 1'b0 || bus.fifo_count !== 2'd0) begin
                n_err++; $display("FAIL mrst_stale%0d got %b/%0d exp 0/0", k, bus.rf_we, bus.fifo_count); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        test_reset();
        reset = 1'b0;
        cyc();
        test_priority();
        test_full();
        test_starve();
        test_zero();
        test_latency();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Schedules the single register-file write port between the pipeline writeback result and results from the multi-cycle multiply/divide unit (MDU).
- The writeback-stage result always has priority. MDU results are queued in a small FIFO and drained in cycles where the pipeline does not write.
- A starvation counter forces a pipeline stall so queued MDU results cannot wait indefinitely.
- Sits between the writeback mux / MDU and the register file write port.

Parameters:
- DEPTH, 2, MDU result FIFO entries; power of 2, at least 2.
- STARVE_MAX, 4, consecutive blocked cycles with a non-empty FIFO before a stall is forced; range 1..15.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pipe_we  input  1  writeback-stage RegWrite.
- pipe_waddr  input  AW  writeback destination register.
- pipe_wdata  input  DW  writeback result (ALU/mem mux output).
- mdu_valid  input  1  MDU result valid.
- mdu_waddr  input  AW  MDU destination register.
- mdu_wdata  input  DW  MDU result.
- mdu_ready  output  1  arbiter can accept an MDU result.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  AW  register-file write address (registered).
- rf_wdata  output  DW  register-file write data (registered).
- pipe_stall  output  1  upstream pipeline stall request (registered).
- fifo_count  output  log2(DEPTH)+1  number of queued MDU entries.

Behaviour:
- Reset, asynchronous, active-high. Asserted state:
  - rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0.
  - FIFO empty, fifo_count=0, starve counter=0, FSM=NORMAL.
  - Reset mid-operation discards all queued entries.
- Pipeline request: pipe_req = pipe_we && (pipe_waddr != 0). A write to $0 is not a request and leaves the port free.
- MDU handshake:
  - mdu_ready = (fifo_count < DEPTH). This is combinational from state and does not depend on mdu_valid.
  - Transfer occurs when mdu_valid && mdu_ready.
  - A transfer with mdu_waddr==0 is accepted and discarded (not queued).
- Port grant, evaluated each cycle; rf_* are loaded at the clock edge:
  - pipe_req=1: rf_we=1 with pipe_waddr/pipe_wdata. Latency 1 cycle.
  - pipe_req=0 and FIFO non-empty: pop the head and load it onto rf_*.
  - Otherwise: rf_we=0; rf_waddr/rf_wdata hold their previous values.
- FIFO order and timing:
  - Strict FIFO order.
  - Push and pop in the same cycle are allowed; fifo_count is unchanged.
  - Entry accepted in cycle N drives rf_* no earlier than cycle N+2.
  - Pointers wrap modulo DEPTH.
- Starve counter:
  - Increments, saturating at STARVE_MAX, in each cycle where the FIFO is non-empty and pipe_req=1.
  - Clears on any pop, and whenever the FIFO is empty.
- FSM:
  - NORMAL: pipe_stall=0. Go to FORCE when the counter reaches STARVE_MAX.
  - FORCE: pipe_stall=1. In-flight pipeline writes are still granted.
  - FORCE exits to NORMAL on the edge where a pop occurs. pipe_stall deasserts the following cycle.
- Same-register ordering: a pipeline write and a queued MDU entry to the same rd are written in grant order, with no merging.
- fifo_count reflects registered state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, pipe_req=0 and an MDU transfer occurs, the result is loaded directly onto rf_* at that edge without entering the FIFO. Latency is 1 cycle and fifo_count is unchanged.
- Undefined: every MDU result passes through the FIFO, with minimum latency 2.

Test Plan:
- Reset check: assert reset mid-run with 2 entries queued -> immediately rf_we=0, pipe_stall=0, fifo_count=0, mdu_ready=1. After release, no stale writes appear.
- Pipeline priority:
  - Stimulus: pipe_we=1, waddr=8, wdata=0xDEADBEEF every cycle; MDU pushes waddr=9, data=0x11 → fifo_count=1.
  - pipe_we drops after 2 cycles → next edge rf_we=1, rf_waddr=9, rf_wdata=0x11.
- Full FIFO:
  - Stimulus: DEPTH=2, pipe_we=1 continuously, 3 MDU valids.
  - Required: mdu_ready=0 after 2 accepts, third result held by the MDU, no loss or duplication. Pop order matches push order.
- Starvation:
  - Stimulus: STARVE_MAX=4, FIFO holds 1 entry, pipe_we=1 (waddr≠0) continuously.
  - Required: pipe_stall=1 after 4 blocked cycles. Once pipe_we=0, the entry pops and pipe_stall returns to 0 the cycle after.
- $0 handling:
  - pipe_we=1, waddr=0, with the FIFO holding an entry → the MDU entry is granted that cycle.
  - MDU result to waddr=0 → accepted, fifo_count stays 0, no rf write.
- Bypass (WB_BYPASS_EN defined): idle port, MDU result waddr=3, data=0x5 in cycle N → rf_we=1, rf_waddr=3, rf_wdata=0x5 in cycle N+1, fifo_count=0. Without the macro the write appears in cycle N+2.
